// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS           = 8;
  localparam int TICK_DIV_DEFAULT     = 100_000;
  localparam int BLANK_CYCLES_DEFAULT = 64;

  // Bit i set when digit i is at or below the most significant nonzero nibble; digit 0 always set.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] w);
    logic [NUM_DIGITS-1:0] m;
    logic seen;
    m    = {NUM_DIGITS{1'b0}};
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen = seen | (w[4*i +: 4] != 4'h0);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: tick is high on the last cycle of every TICK_DIV-cycle slot.
module scan_tick_gen
  import display_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] tick_cnt_r;

  // Free-running slot counter, wraps at TICK_DIV-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= {CW{1'b0}};
    end else if (tick_cnt_r == CW'(TICK_DIV - 1)) begin
      tick_cnt_r <= {CW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + CW'(1);
    end
  end

  assign tick = (tick_cnt_r == CW'(TICK_DIV - 1));

endmodule

// File: rtl/display_scan_mux.sv
// Eight-digit seven-segment scan controller with frame-synchronous double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN also blanks digits above the top nonzero nibble.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);

  scan_state_t             state_r, state_s;
  logic [2:0]              idx_r, idx_s;
  logic [BW-1:0]           blank_cnt_r, blank_cnt_s;
  logic [4*NUM_DIGITS-1:0] active_r, active_s, pending_r;
  logic                    pend_flag_r;
  logic                    tick_s, wrap_s;
  logic [NUM_DIGITS-1:0]   en_s, anode_s;
  logic [3:0]              nibble_s;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  assign wrap_s = tick_s & (idx_r == 3'd7);

  // Slot FSM next state: blank window, then anode on until the slot tick
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    blank_cnt_s = blank_cnt_r;
    case (state_r)
      BLANK: begin
        if (tick_s) begin
          idx_s       = idx_r + 3'd1;
          blank_cnt_s = {BW{1'b0}};
        end else if (blank_cnt_r == BW'(BLANK_CYCLES - 1)) begin
          state_s     = ON;
          blank_cnt_s = {BW{1'b0}};
        end else begin
          blank_cnt_s = blank_cnt_r + BW'(1);
        end
      end
      ON: begin
        if (tick_s) begin
          state_s = BLANK;
          idx_s   = idx_r + 3'd1;
        end else begin
          state_s = ON;
        end
      end
      default: begin
        state_s     = BLANK;
        idx_s       = 3'd0;
        blank_cnt_s = {BW{1'b0}};
      end
    endcase
  end

  // Active word only changes at the frame wrap; a coincident load bypasses the pending buffer
  always_comb begin
    active_s = active_r;
    if (wrap_s) begin
      if (value_valid) begin
        active_s = value;
      end else if (pend_flag_r) begin
        active_s = pending_r;
      end else begin
        active_s = active_r;
      end
    end else begin
      active_s = active_r;
    end
  end

  // Output decode from next-cycle state so the registered outputs line up with the slot
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    en_s = digit_en & lz_mask(active_s);
`else
    en_s = digit_en;
`endif
    anode_s  = {NUM_DIGITS{1'b1}};
    nibble_s = active_s[{idx_s, 2'b00} +: 4];
    if (state_s == ON && en_s[idx_s]) begin
      anode_s = ~(NUM_DIGITS'(1) << idx_s);
    end else begin
      anode_s = {NUM_DIGITS{1'b1}};
    end
  end

  // Scan state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= BLANK;
      idx_r       <= 3'd0;
      blank_cnt_r <= {BW{1'b0}};
      active_r    <= {(4*NUM_DIGITS){1'b0}};
      nibble      <= 4'h0;
      anode       <= {NUM_DIGITS{1'b1}};
      frame_done  <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      blank_cnt_r <= blank_cnt_s;
      active_r    <= active_s;
      nibble      <= nibble_s;
      anode       <= anode_s;
      frame_done  <= wrap_s;
    end
  end

  // Pending buffer: last load in a frame wins, consumed at the wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r   <= {(4*NUM_DIGITS){1'b0}};
      pend_flag_r <= 1'b0;
    end else if (wrap_s) begin
      pend_flag_r <= 1'b0;
    end else if (value_valid) begin
      pending_r   <= value;
      pend_flag_r <= 1'b1;
    end else begin
      pend_flag_r <= pend_flag_r;
    end
  end

endmodule
